// File: rtl/vdp_mac_feeder.sv
// vdp_mac_feeder: upstream sequencer for a K-cycle vector dot-product MAC.
//  Accepts a pair of K-element signed vectors over valid/ready, streams one
//  element pair per cycle into the MAC (generating its per-vector reset),
//  captures the final accumulation and presents it over valid/ready.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  in_valid/in_ready        input handshake for g_vec/e_vec (N*K bits each)
//  mac_rst, mac_g, mac_e    drive to the MAC (reset, element pair)
//  mac_o                    MAC running sum including the current pair
//  out_valid/out_ready      output handshake for out_data (2N+K-1 bits)
//  busy                     feeder not idle
module vdp_mac_feeder #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*K-1:0]       g_vec,
  input  logic [N*K-1:0]       e_vec,
  output logic                 mac_rst,
  output logic [N-1:0]         mac_g,
  output logic [N-1:0]         mac_e,
  input  logic [2*N+K-2:0]     mac_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N+K-2:0]     out_data,
  output logic                 busy
);

  localparam int unsigned VW = N * K;
  localparam int unsigned OW = 2 * N + K - 1;
  localparam int unsigned IW = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [VW-1:0] g_q;
  logic [VW-1:0] e_q;
  logic [N-1:0]  g_elem;
  logic [N-1:0]  e_elem;
  logic          last_elem;

  assign last_elem = (idx == IW'(K - 1));

  // Sequencer: latch vectors, walk idx across the elements, capture the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      g_q       <= '0;
      e_q       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            g_q   <= g_vec;
            e_q   <= e_vec;
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (last_elem) begin
            out_data  <= mac_o;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Accepting the next pair in the release cycle avoids a bubble.
            if (in_valid) begin
              g_q   <= g_vec;
              e_q   <= e_vec;
              idx   <= '0;
              state <= STREAM;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Element select for the current idx.
  always_comb begin
    g_elem = '0;
    e_elem = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (idx == IW'(i)) begin
        g_elem = g_q[i*N +: N];
        e_elem = e_q[i*N +: N];
      end
    end
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign busy     = (state != IDLE);
  // The MAC is held in reset outside STREAM; idx 0 starts a fresh sum.
  assign mac_rst  = (state != STREAM) || (idx == '0);
  assign mac_g    = (state == STREAM) ? g_elem : '0;
  assign mac_e    = (state == STREAM) ? e_elem : '0;

endmodule

// File: tb/tb_vdp_mac_feeder.sv
// Bench for vdp_mac_feeder: two instances (K=4 and K=1), each fed by a
// behavioural MAC model; results are compared against a dot-product reference.
module tb_vdp_mac_feeder;

  localparam int N   = 8;
  localparam int KA  = 4;
  localparam int KB  = 1;
  localparam int OWA = 2 * N + KA - 1;
  localparam int OWB = 2 * N + KB - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // K=4 instance signals
  logic              a_in_valid, a_in_ready, a_mac_rst, a_out_valid, a_out_ready, a_busy;
  logic [N*KA-1:0]   a_g_vec, a_e_vec;
  logic [N-1:0]      a_mac_g, a_mac_e;
  logic [OWA-1:0]    a_mac_o, a_out_data, a_acc, a_prod;

  // K=1 instance signals
  logic              b_in_valid, b_in_ready, b_mac_rst, b_out_valid, b_out_ready, b_busy;
  logic [N*KB-1:0]   b_g_vec, b_e_vec;
  logic [N-1:0]      b_mac_g, b_mac_e;
  logic [OWB-1:0]    b_mac_o, b_out_data, b_acc, b_prod;

  vdp_mac_feeder #(.N(N), .K(KA)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .g_vec(a_g_vec), .e_vec(a_e_vec),
    .mac_rst(a_mac_rst), .mac_g(a_mac_g), .mac_e(a_mac_e), .mac_o(a_mac_o),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy)
  );

  vdp_mac_feeder #(.N(N), .K(KB)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .g_vec(b_g_vec), .e_vec(b_e_vec),
    .mac_rst(b_mac_rst), .mac_g(b_mac_g), .mac_e(b_mac_e), .mac_o(b_mac_o),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
  );

  // Behavioural MAC: o = (rst ? 0 : acc) + g*e, acc <= o each cycle.
  assign a_prod  = {{(OWA-N){a_mac_g[N-1]}}, a_mac_g} * {{(OWA-N){a_mac_e[N-1]}}, a_mac_e};
  assign a_mac_o = (a_mac_rst ? '0 : a_acc) + a_prod;
  always_ff @(posedge clk or posedge rst)
    if (rst) a_acc <= '0; else a_acc <= a_mac_o;

  assign b_prod  = {{(OWB-N){b_mac_g[N-1]}}, b_mac_g} * {{(OWB-N){b_mac_e[N-1]}}, b_mac_e};
  assign b_mac_o = (b_mac_rst ? '0 : b_acc) + b_prod;
  always_ff @(posedge clk or posedge rst)
    if (rst) b_acc <= '0; else b_acc <= b_mac_o;

  int nvec = 0;
  int nerr = 0;

  function automatic logic [OWA-1:0] ref_dot(input logic [N*KA-1:0] g, input logic [N*KA-1:0] e);
    longint s;
    logic signed [N-1:0] ge, ee;
    s = 0;
    for (int i = 0; i < KA; i++) begin
      ge = g[i*N +: N];
      ee = e[i*N +: N];
      s += longint'(ge) * longint'(ee);
    end
    return OWA'(s);
  endfunction

  function automatic logic [N*KA-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [31:0] t0, t1, t2, t3;
    t0 = v0; t1 = v1; t2 = v2; t3 = v3;
    return {t3[7:0], t2[7:0], t1[7:0], t0[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_in_valid = 0; a_out_ready = 0; a_g_vec = '0; a_e_vec = '0;
    b_in_valid = 0; b_out_ready = 0; b_g_vec = '0; b_e_vec = '0;
    rst = 1;
    tick; tick;
    nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    nvec++; if (a_out_data !== '0) begin nerr++; $display("FAIL reset_out_data: got %0d expected 0", a_out_data); end
    nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    nvec++; if (a_mac_rst !== 1'b1 || a_mac_g !== '0 || a_mac_e !== '0) begin
      nerr++; $display("FAIL reset_mac: got rst=%b g=%0h e=%0h expected 1/0/0", a_mac_rst, a_mac_g, a_mac_e); end
    rst = 0;
    tick;
    nvec++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_k1: got valid=%b ready=%b expected 0/1", b_out_valid, b_in_ready); end
  endtask

  // Directed vector; leaves the DUT in HOLD with out_ready low.
  task automatic test_scenario1;
    int g[4] = '{23, -23, 5, -128};
    int e[4] = '{99, 99, -7, -128};
    logic [N-1:0] gx, ex;
    a_g_vec = pack4(g[0], g[1], g[2], g[3]);
    a_e_vec = pack4(e[0], e[1], e[2], e[3]);
    a_out_ready = 0;
    a_in_valid = 1;
    tick;
    a_in_valid = 0;
    for (int i = 0; i < KA; i++) begin
      gx = N'(g[i]); ex = N'(e[i]);
      nvec++; if (a_mac_rst !== (i == 0)) begin
        nerr++; $display("FAIL s1_mac_rst idx%0d: got %b expected %b", i, a_mac_rst, (i == 0)); end
      nvec++; if (a_mac_g !== gx || a_mac_e !== ex) begin
        nerr++; $display("FAIL s1_elem idx%0d: got %0h/%0h expected %0h/%0h", i, a_mac_g, a_mac_e, gx, ex); end
      nvec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
        nerr++; $display("FAIL s1_stream idx%0d: got valid=%b ready=%b expected 0/0", i, a_out_valid, a_in_ready); end
      tick;
    end
    nvec++; if (a_out_valid !== 1'b1 || a_out_data !== OWA'(16349)) begin
      nerr++; $display("FAIL s1_result: got valid=%b data=%0d expected 1/16349", a_out_valid, a_out_data); end
  endtask

  task automatic test_stall;
    for (int c = 0; c < 10; c++) begin
      tick;
      nvec++; if (a_out_valid !== 1'b1 || a_out_data !== OWA'(16349) || a_in_ready !== 1'b0) begin
        nerr++; $display("FAIL stall c%0d: got valid=%b data=%0d ready=%b expected 1/16349/0",
                         c, a_out_valid, a_out_data, a_in_ready); end
    end
    a_out_ready = 1;
    #1;
    nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL stall_bypass: got %b expected 1", a_in_ready); end
    tick;
    a_out_ready = 0;
    nvec++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      nerr++; $display("FAIL stall_release: got valid=%b busy=%b expected 0/0", a_out_valid, a_busy); end
  endtask

  task automatic test_back_to_back;
    logic [N*KA-1:0] ga, ea, gb, eb;
    ga = $urandom; ea = $urandom; gb = $urandom; eb = $urandom;
    a_g_vec = ga; a_e_vec = ea; a_in_valid = 1; a_out_ready = 1;
    tick;
    a_g_vec = gb; a_e_vec = eb;
    repeat (KA) tick;
    nvec++; if (a_out_valid !== 1'b1 || a_out_data !== ref_dot(ga, ea) || a_in_ready !== 1'b1) begin
      nerr++; $display("FAIL b2b_first: got valid=%b data=%0d ready=%b expected 1/%0d/1",
                       a_out_valid, a_out_data, a_in_ready, ref_dot(ga, ea)); end
    tick;
    a_in_valid = 0;
    nvec++; if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_mac_rst !== 1'b1) begin
      nerr++; $display("FAIL b2b_accept: got valid=%b busy=%b mac_rst=%b expected 0/1/1",
                       a_out_valid, a_busy, a_mac_rst); end
    repeat (KA) tick;
    nvec++; if (a_out_valid !== 1'b1 || a_out_data !== ref_dot(gb, eb)) begin
      nerr++; $display("FAIL b2b_second: got valid=%b data=%0d expected 1/%0d",
                       a_out_valid, a_out_data, ref_dot(gb, eb)); end
    tick;
    a_out_ready = 0;
    nvec++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      nerr++; $display("FAIL b2b_idle: got valid=%b busy=%b expected 0/0", a_out_valid, a_busy); end
  endtask

  task automatic test_reset_midstream;
    int cnt;
    a_g_vec = $urandom; a_e_vec = $urandom; a_in_valid = 1; a_out_ready = 1;
    tick;
    a_in_valid = 0;
    tick; tick;
    rst = 1;
    #1;
    nvec++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_mac_rst !== 1'b1 || a_mac_g !== '0 || a_in_ready !== 1'b1) begin
      nerr++; $display("FAIL midrst: got busy=%b valid=%b mac_rst=%b mac_g=%0h ready=%b expected 0/0/1/0/1",
                       a_busy, a_out_valid, a_mac_rst, a_mac_g, a_in_ready); end
    tick;
    rst = 0;
    a_g_vec = 32'h01010101; a_e_vec = 32'h01010101; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    cnt = 0;
    while (!a_out_valid && cnt < 3 * KA) begin tick; cnt++; end
    nvec++; if (cnt !== KA || a_out_data !== OWA'(4)) begin
      nerr++; $display("FAIL midrst_next: got latency=%0d data=%0d expected %0d/4", cnt, a_out_data, KA); end
    tick;
    a_out_ready = 0;
  endtask

  task automatic test_k1;
    b_g_vec = 8'hE9; b_e_vec = 8'h9D; b_out_ready = 0; b_in_valid = 1;
    tick;
    b_in_valid = 0;
    nvec++; if (b_mac_rst !== 1'b1 || b_busy !== 1'b1 || b_mac_g !== 8'hE9 || b_out_valid !== 1'b0) begin
      nerr++; $display("FAIL k1_stream: got mac_rst=%b busy=%b mac_g=%0h valid=%b expected 1/1/e9/0",
                       b_mac_rst, b_busy, b_mac_g, b_out_valid); end
    tick;
    nvec++; if (b_out_valid !== 1'b1 || b_out_data !== OWB'(2277)) begin
      nerr++; $display("FAIL k1_result: got valid=%b data=%0d expected 1/2277", b_out_valid, b_out_data); end
    b_out_ready = 1;
    tick;
    b_out_ready = 0;
    nvec++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
      nerr++; $display("FAIL k1_release: got valid=%b busy=%b expected 0/0", b_out_valid, b_busy); end
  endtask

  task automatic test_max;
    a_g_vec = 32'h80808080; a_e_vec = 32'h80808080; a_out_ready = 0; a_in_valid = 1;
    tick;
    a_in_valid = 0;
    repeat (KA) tick;
    nvec++; if (a_out_valid !== 1'b1 || a_out_data !== OWA'(65536)) begin
      nerr++; $display("FAIL max_neg: got valid=%b data=%0d expected 1/65536", a_out_valid, a_out_data); end
    a_out_ready = 1;
    tick;
    a_out_ready = 0;
  endtask

  task automatic test_random;
    logic [N*KA-1:0] g, e;
    logic [OWA-1:0] exp_v;
    int cnt, stall;
    for (int it = 0; it < 40; it++) begin
      g = $urandom; e = $urandom;
      if (it % 7 == 3) g = 32'h80808080;
      if (it % 5 == 1) e = 32'h7f807f80;
      exp_v = ref_dot(g, e);
      nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL rnd_ready it%0d: got %b expected 1", it, a_in_ready); end
      a_g_vec = g; a_e_vec = e; a_in_valid = 1;
      tick;
      a_in_valid = 0;
      a_g_vec = $urandom; a_e_vec = $urandom;
      cnt = 0;
      while (!a_out_valid && cnt < 3 * KA) begin tick; cnt++; end
      nvec++; if (cnt !== KA || a_out_data !== exp_v) begin
        nerr++; $display("FAIL rnd_result it%0d: got latency=%0d data=%0d expected %0d/%0d",
                         it, cnt, a_out_data, KA, exp_v); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        tick;
        nvec++; if (a_out_valid !== 1'b1 || a_out_data !== exp_v) begin
          nerr++; $display("FAIL rnd_hold it%0d: got valid=%b data=%0d expected 1/%0d", it, a_out_valid, a_out_data, exp_v); end
      end
      a_out_ready = 1;
      tick;
      a_out_ready = 0;
    end
  endtask

  initial begin
    test_reset;
    test_scenario1;
    test_stall;
    test_back_to_back;
    test_reset_midstream;
    test_k1;
    test_max;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
